// File: rtl/phy_rx_lane_arbiter.sv
// Two-lane PHY receive controller: link training FSM, per-lane byte FIFOs,
// and round-robin merge onto a single valid/ready byte stream.
// Optional per-lane accepted-byte counters under `RX_LANE_STATS_EN.

module phy_rx_lane_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              empty,
  output logic              full,
  output logic              accept
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH-1:0][DATA_W-1:0] mem_q;
  logic do_push, do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign accept  = do_push && !flush;
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end
endmodule

module phy_rx_lane_arbiter #(
  parameter int                DATA_W     = 8,
  parameter int                FIFO_DEPTH = 4,
  parameter logic [DATA_W-1:0] COMMA      = 8'hBC
) (
  input  logic              clk_32f,
  input  logic              reset_L,
  input  logic              active_0,
  input  logic              valid_0,
  input  logic [DATA_W-1:0] data_in_0,
  input  logic              active_1,
  input  logic              valid_1,
  input  logic [DATA_W-1:0] data_in_1,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_lane,
`ifdef RX_LANE_STATS_EN
  output logic [15:0]       count_0,
  output logic [15:0]       count_1,
`endif
  output logic              link_up,
  output logic              overflow_0,
  output logic              overflow_1
);
  localparam int NUM_LANES = 2;

  typedef enum logic [1:0] {IDLE, TRAIN, LINK_UP} state_t;
  state_t state_q, state_d;

  logic [NUM_LANES-1:0]             active, valid, push, pop, empty, full, accept;
  logic [NUM_LANES-1:0][DATA_W-1:0] din, dout;
  logic [NUM_LANES-1:0]             ovf_q, ovf_d;
  logic                             out_valid_q, out_valid_d;
  logic [DATA_W-1:0]                out_data_q, out_data_d;
  logic                             out_lane_q, out_lane_d;
  logic                             last_lane_q, last_lane_d;
  logic                             both_active, flush, load, sel;

  assign active      = {active_1, active_0};
  assign valid       = {valid_1, valid_0};
  assign din         = {data_in_1, data_in_0};
  assign both_active = &active;
  // Losing either lane while up drops everything in flight; the link must retrain.
  assign flush       = (state_q == LINK_UP) && !both_active;
  assign load        = !out_valid_q || out_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|active)     state_d = TRAIN;
      TRAIN:   if (both_active) state_d = LINK_UP;
               else if (!(|active)) state_d = IDLE;
      LINK_UP: if (!both_active) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  genvar g;
  generate
    for (g = 0; g < NUM_LANES; g++) begin : g_lane
      assign push[g]  = (state_q == LINK_UP) && both_active && valid[g] && (din[g] != COMMA);
      assign ovf_d[g] = ovf_q[g] || (push[g] && full[g] && !pop[g]);

      phy_rx_lane_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk    (clk_32f),
        .rst_n  (reset_L),
        .flush  (flush),
        .push   (push[g]),
        .pop    (pop[g]),
        .din    (din[g]),
        .dout   (dout[g]),
        .empty  (empty[g]),
        .full   (full[g]),
        .accept (accept[g])
      );
    end
  endgenerate

  // Round-robin pointer only moves on contention, so a lone lane never steals priority.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_lane_d  = out_lane_q;
    last_lane_d = last_lane_q;
    pop         = '0;
    sel         = 1'b0;
    if (!empty[0] && !empty[1]) sel = ~last_lane_q;
    else if (!empty[1])         sel = 1'b1;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (load) begin
      if (!(&empty)) begin
        out_valid_d = 1'b1;
        out_data_d  = dout[sel];
        out_lane_d  = sel;
        pop[sel]    = 1'b1;
        if (!empty[0] && !empty[1]) last_lane_d = sel;
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_lane_q  <= 1'b0;
      last_lane_q <= 1'b1;
      ovf_q       <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_lane_q  <= out_lane_d;
      last_lane_q <= last_lane_d;
      ovf_q       <= ovf_d;
    end
  end

`ifdef RX_LANE_STATS_EN
  logic [NUM_LANES-1:0][15:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    for (int i = 0; i < NUM_LANES; i++)
      if (accept[i]) count_d[i] = count_q[i] + 16'd1;
  end

  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) count_q <= '0;
    else          count_q <= count_d;
  end

  assign count_0 = count_q[0];
  assign count_1 = count_q[1];
`endif

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_lane   = out_lane_q;
  assign link_up    = (state_q == LINK_UP);
  assign overflow_0 = ovf_q[0];
  assign overflow_1 = ovf_q[1];
endmodule

// File: tb/tb_phy_rx_lane_arbiter.sv
// Directed bench for phy_rx_lane_arbiter: expected {lane,byte} pairs are queued
// as stimulus is driven and compared as the output stream hands them off.

module tb_phy_rx_lane_arbiter;
  logic       clk_32f = 1'b0;
  logic       reset_L;
  logic       active_0, valid_0, active_1, valid_1, out_ready;
  logic [7:0] data_in_0, data_in_1;
  logic       out_valid, out_lane, link_up, overflow_0, overflow_1;
  logic [7:0] out_data;
`ifdef RX_LANE_STATS_EN
  logic [15:0] count_0, count_1;
`endif

  int total = 0;
  int bad   = 0;
  logic [8:0] exp_q[$];

  always #5 clk_32f = ~clk_32f;

  phy_rx_lane_arbiter dut (
    .clk_32f    (clk_32f),
    .reset_L    (reset_L),
    .active_0   (active_0),
    .valid_0    (valid_0),
    .data_in_0  (data_in_0),
    .active_1   (active_1),
    .valid_1    (valid_1),
    .data_in_1  (data_in_1),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_lane   (out_lane),
`ifdef RX_LANE_STATS_EN
    .count_0    (count_0),
    .count_1    (count_1),
`endif
    .link_up    (link_up),
    .overflow_0 (overflow_0),
    .overflow_1 (overflow_1)
  );

  task automatic step();
    @(posedge clk_32f);
    #1;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    active_0 = 0; active_1 = 0; valid_0 = 0; valid_1 = 0;
    data_in_0 = 0; data_in_1 = 0; out_ready = 1;
    reset_L = 0;
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_link_up", link_up, 0);
    chk("rst_ovf", {overflow_1, overflow_0}, 0);
    step();
    reset_L = 1;
  endtask

  task automatic train();
    active_0 = 1; active_1 = 1;
    step();
    step();
    chk("train_link_up", link_up, 1);
  endtask

  // Requires out_ready=1: every cycle with out_valid is a handoff at the next edge.
  task automatic drain(int budget);
    int n = 0;
    logic [8:0] e;
    while (exp_q.size() > 0 && n < budget) begin
      if (out_valid) begin
        e = exp_q.pop_front();
        chk("out_lane_data", {out_lane, out_data}, e);
      end
      step();
      n++;
    end
    if (exp_q.size() > 0) begin
      chk("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  initial begin
    reset_L = 0;
    do_reset();

    // Training only: lane 0 bytes must be ignored
    active_0 = 1;
    step();
    chk("train_no_link", link_up, 0);
    valid_0 = 1; data_in_0 = 8'h11;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("train_ignored", out_valid, 0);
    end
    valid_0 = 0;
    do_reset();

    // Single byte latency
    train();
    valid_0 = 1; data_in_0 = 8'hA5;
    exp_q.push_back({1'b0, 8'hA5});
    step();
    valid_0 = 0;
    chk("latency_not_yet", out_valid, 0);
    step();
    chk("latency_valid", out_valid, 1);
    drain(10);
    chk("single_done", out_valid, 0);

    // Both lanes streaming alternate starting with lane 0
    do_reset();
    train();
    valid_0 = 1; valid_1 = 1; data_in_0 = 8'h01; data_in_1 = 8'h81;
    exp_q.push_back({1'b0, 8'h01});
    exp_q.push_back({1'b1, 8'h81});
    step();
    data_in_0 = 8'h02; data_in_1 = 8'h82;
    exp_q.push_back({1'b0, 8'h02});
    exp_q.push_back({1'b1, 8'h82});
    step();
    valid_0 = 0; valid_1 = 0;
    drain(20);

    // Comma is filtered
    valid_0 = 1; data_in_0 = 8'hBC;
    step();
    data_in_0 = 8'h3C;
    exp_q.push_back({1'b0, 8'h3C});
    step();
    valid_0 = 0;
    drain(10);
    for (int i = 0; i < 3; i++) begin
      chk("comma_no_extra", out_valid, 0);
      step();
    end

    // Backpressure and overflow
    out_ready = 0;
    valid_0 = 1;
    for (int i = 0; i < 6; i++) begin
      data_in_0 = 8'h10 + 8'(i);
      step();
      if (i >= 1) chk("hold_data", {out_valid, out_data}, {1'b1, 8'h10});
      if (i == 4) chk("ovf_not_yet", overflow_0, 0);
    end
    valid_0 = 0;
    chk("ovf_set", overflow_0, 1);
    chk("ovf1_clear", overflow_1, 0);
    step();
    chk("hold_data_idle", {out_valid, out_data}, {1'b1, 8'h10});
    for (int i = 0; i < 5; i++) exp_q.push_back({1'b0, 8'h10 + 8'(i)});
    out_ready = 1;
    drain(20);
    chk("ovf_sticky", overflow_0, 1);

    // Link drop flushes buffered bytes
    out_ready = 0;
    valid_0 = 1;
    for (int i = 0; i < 3; i++) begin
      data_in_0 = 8'h20 + 8'(i);
      step();
    end
    valid_0 = 0;
    chk("pre_drop_valid", out_valid, 1);
    active_1 = 0;
    step();
    chk("drop_link", link_up, 0);
    chk("drop_out_valid", out_valid, 0);
    active_1 = 1;
    step();
    step();
    chk("retrain_link", link_up, 1);
    out_ready = 1;
    for (int i = 0; i < 6; i++) begin
      chk("no_stale", out_valid, 0);
      step();
    end
    chk("ovf_kept_after_drop", overflow_0, 1);

    do_reset();
    chk("ovf_cleared", overflow_0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
